pc_sequencer: RTL and testbench

- Fetch/next-PC stage of the LEGv8 datapath. Holds the architectural PC and fetches from instruction memory over a req/ack handshake.
- Presents each fetched instruction to decode, where the sign extender consumes its immediate fields.
- Consumes the sign-extended immediate (BusImm) and branch controls back from decode/ALU to pick PC+4 or PC+BusImm.
- Adds an imem timeout watchdog, a sticky fault and a retired-instruction counter.

---
 rtl/pc_sequencer_pkg.sv | 33 +++
 rtl/pc_sequencer_next_pc_calc.sv | 34 +++
 rtl/pc_sequencer.sv | 148 ++++++++++++++
 tb/tb_pc_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_sequencer_pkg
//   Shared definitions for the LEGv8 fetch/next-PC stage: sequencer state
//   encodings, the sign-extender immediate-format controls used by decode,
//   and the branch-decision helper shared with the single-cycle datapath.
// -----------------------------------------------------------------------------
package pc_sequencer_pkg;

  // Sequencer states; encodings are fixed so they can be observed on a bus.
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // Sign-extender immediate-format selects (consumed in decode).
  localparam logic [1:0] SE_ITYPE  = 2'b00;
  localparam logic [1:0] SE_DTYPE  = 2'b01;
  localparam logic [1:0] SE_BTYPE  = 2'b10;
  localparam logic [1:0] SE_CBTYPE = 2'b11;

  // Sequential fall-through distance in bytes.
  localparam logic [63:0] INSTR_STEP = 64'd4;

  // B is always taken; CBZ-style branches are taken when the ALU reports zero.
  function automatic logic branch_taken(input logic branch,
                                        input logic uncondbranch,
                                        input logic alu_zero);
    return uncondbranch | (branch & alu_zero);
  endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_calc.sv
// -----------------------------------------------------------------------------
// next_pc_calc
//   Combinational next-PC selection: PC+4 or PC+BusImm depending on the branch
//   controls, plus a flag when the resulting target is not word aligned.
//   Reusable by the single-cycle datapath.
// Ports:
//   instr_pc     in  64  PC of the instruction being retired
//   BusImm       in  64  sign-extended, word-scaled branch offset
//   Branch       in  1   conditional-branch control
//   Uncondbranch in  1   unconditional-branch control
//   ALUZero      in  1   ALU zero flag
//   next_pc      out 64  selected next PC (wraps mod 2^64)
//   misalign     out 1   next_pc[1:0] != 0
// -----------------------------------------------------------------------------
module next_pc_calc
  import pc_sequencer_pkg::*;
(
  input  logic [63:0] instr_pc,
  input  logic [63:0] BusImm,
  input  logic        Branch,
  input  logic        Uncondbranch,
  input  logic        ALUZero,
  output logic [63:0] next_pc,
  output logic        misalign
);

  logic taken;

  assign taken    = branch_taken(Branch, Uncondbranch, ALUZero);
  // Plain 64-bit adds; carry-out is intentionally discarded.
  assign next_pc  = taken ? (instr_pc + BusImm) : (instr_pc + INSTR_STEP);
  assign misalign = |next_pc[1:0];

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   LEGv8 fetch/next-PC stage. Holds the architectural PC, fetches one
//   instruction at a time over a req/ack handshake, presents it to decode and
//   advances the PC from the branch controls returned by decode/ALU. An imem
//   watchdog and misaligned targets drop the stage into a sticky FAULT state
//   that only reset leaves. No prefetch: each instruction costs FETCH + ISSUE.
// Ports:
//   CLK, resetl           clock / asynchronous active-low reset
//   startpc      in  64   boot PC, sampled on the first clock after reset
//   imem_req/addr out     fetch request and address (valid in FETCH)
//   imem_ack/data in      fetch response
//   instr_valid  out      instr/instr_pc valid to decode (ISSUE)
//   instr_ready  in       decode accepts/retires the current instruction
//   instr, instr_pc out   latched instruction and its PC
//   BusImm, Branch, Uncondbranch, ALUZero in   next-PC controls for instr
//   currentpc    out 64   architectural PC
//   fault        out      sticky error flag
//   retired      out      instructions accepted since reset
// -----------------------------------------------------------------------------
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             resetl,
  input  logic [63:0]      startpc,
  output logic             imem_req,
  output logic [63:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_data,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr,
  output logic [63:0]      instr_pc,
  input  logic [63:0]      BusImm,
  input  logic             Branch,
  input  logic             Uncondbranch,
  input  logic             ALUZero,
  output logic [63:0]      currentpc,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  // +1 keeps the width >= 1 even when TIMEOUT == 1.
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [63:0]      ipc_q, ipc_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  logic [63:0]      next_pc;
  logic             misalign;

  next_pc_calc u_next_pc_calc (
    .instr_pc     (ipc_q),
    .BusImm       (BusImm),
    .Branch       (Branch),
    .Uncondbranch (Uncondbranch),
    .ALUZero      (ALUZero),
    .next_pc      (next_pc),
    .misalign     (misalign)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ret_d   = ret_q;
    tmr_d   = tmr_q;

    unique case (state_q)
      ST_BOOT: begin
        pc_d    = startpc;
        tmr_d   = '0;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // An ack in the last allowed cycle still wins over the watchdog.
        if (imem_ack) begin
          instr_d = imem_data;
          ipc_d   = pc_q;
          tmr_d   = '0;
          state_d = ST_ISSUE;
        end else if (tmr_q == TMR_LAST) begin
          state_d = ST_FAULT;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_ISSUE: begin
        if (instr_ready) begin
          ret_d = ret_q + CNT_W'(1);
          if (misalign) begin
            state_d = ST_FAULT;
          end else begin
            pc_d    = next_pc;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FAULT: begin
        // Frozen until reset.
      end
    endcase
  end

  // NOTE: reset is asynchronous and active-low so it takes effect mid-fetch
  // without waiting for a clock edge.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q <= ST_BOOT;
      pc_q    <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      ret_q   <= '0;
      tmr_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from
      // the values computed before the edge.
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ret_q   <= ret_d;
      tmr_q   <= tmr_d;
    end
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == ST_ISSUE);
  assign fault       = (state_q == ST_FAULT);
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign currentpc   = pc_q;
  assign retired     = ret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed self-checking bench for pc_sequencer. Inputs are driven and
//   outputs sampled on the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;

  logic             CLK;
  logic             resetl;
  logic [63:0]      startpc;
  logic             imem_req;
  logic [63:0]      imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_data;
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instr;
  logic [63:0]      instr_pc;
  logic [63:0]      BusImm;
  logic             Branch;
  logic             Uncondbranch;
  logic             ALUZero;
  logic [63:0]      currentpc;
  logic             fault;
  logic [CNT_W-1:0] retired;

  pc_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK          (CLK),
    .resetl       (resetl),
    .startpc      (startpc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .BusImm       (BusImm),
    .Branch       (Branch),
    .Uncondbranch (Uncondbranch),
    .ALUZero      (ALUZero),
    .currentpc    (currentpc),
    .fault        (fault),
    .retired      (retired)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One instruction per record, executed back-to-back from the previous
  // record's target; expected values are hand-computed.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
    logic [63:0] imm;
    logic        br;
    logic        ub;
    logic        zero;
    logic [63:0] nxt;
  } vec_t;

  vec_t vecs[8];

  task automatic clear_ctl();
    BusImm       = '0;
    Branch       = 1'b0;
    Uncondbranch = 1'b0;
    ALUZero      = 1'b0;
    instr_ready  = 1'b0;
  endtask

  task automatic reset_and_boot(input logic [63:0] spc);
    @(negedge CLK);
    resetl  = 1'b0;
    startpc = spc;
    @(negedge CLK);
    resetl = 1'b1;
    @(negedge CLK);  // BOOT consumed, now in FETCH
  endtask

  initial begin
    resetl    = 1'b0;
    startpc   = 64'h400;
    imem_ack  = 1'b0;
    imem_data = '0;
    clear_ctl();

    vecs[0] = '{64'h404, 32'h1400_0003, 64'h0000_0000_0000_000C, 1'b0, 1'b1, 1'b0, 64'h410};
    vecs[1] = '{64'h410, 32'h17FF_FFFE, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b1, 1'b0, 64'h408};
    vecs[2] = '{64'h408, 32'hB400_0201, 64'h0000_0000_0000_0040, 1'b1, 1'b0, 1'b0, 64'h40C};
    vecs[3] = '{64'h40C, 32'hB400_0202, 64'h0000_0000_0000_0040, 1'b1, 1'b0, 1'b1, 64'h44C};
    vecs[4] = '{64'h44C, 32'h17FF_FEEC, 64'hFFFF_FFFF_FFFF_FBB0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFC, 32'h8B02_0020, 64'h0000_0000_0000_1234, 1'b0, 1'b0, 1'b1, 64'h0};
    vecs[6] = '{64'h0, 32'hB400_0803, 64'h0000_0000_0000_0100, 1'b1, 1'b0, 1'b1, 64'h100};
    vecs[7] = '{64'h100, 32'h8B03_0040, 64'h0000_0000_0000_0040, 1'b0, 1'b0, 1'b1, 64'h104};

    // ---------------- reset state ----------------
    @(negedge CLK);
    check("rst_req",     imem_req,    0);
    check("rst_valid",   instr_valid, 0);
    check("rst_fault",   fault,       0);
    check("rst_pc",      currentpc,   0);
    check("rst_retired", retired,     0);
    check("rst_instr",   instr,       0);
    resetl = 1'b1;
    check("boot_no_req", imem_req,    0);

    // ---------------- boot + first fetch with backpressure ----------------
    @(negedge CLK);
    check("boot_pc",   currentpc, 64'h400);
    check("boot_req",  imem_req,  1);
    check("boot_addr", imem_addr, 64'h400);
    imem_ack  = 1'b1;
    imem_data = 32'h8B1F_03E0;
    @(negedge CLK);
    imem_ack  = 1'b0;
    imem_data = 32'hDEAD_BEEF;
    check("first_valid",   instr_valid, 1);
    check("first_instr",   instr,       32'h8B1F_03E0);
    check("first_ipc",     instr_pc,    64'h400);
    check("first_req_off", imem_req,    0);
    // Branch inputs during the stall must be ignored.
    BusImm       = 64'h80;
    Uncondbranch = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge CLK);
      check("stall_valid", instr_valid, 1);
      check("stall_instr", instr,       32'h8B1F_03E0);
      check("stall_pc",    currentpc,   64'h400);
    end
    clear_ctl();
    instr_ready = 1'b1;
    @(negedge CLK);
    instr_ready = 1'b0;
    check("seq_pc",      currentpc, 64'h404);
    check("seq_retired", retired,   1);
    check("seq_req",     imem_req,  1);

    // ---------------- table-driven instruction stream ----------------
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      check("vec_req",  imem_req,  1);
      check("vec_addr", imem_addr, vecs[i].pc);
      imem_ack  = 1'b1;
      imem_data = vecs[i].data;
      @(negedge CLK);
      imem_ack     = 1'b0;
      check("vec_valid", instr_valid, 1);
      check("vec_instr", instr,       vecs[i].data);
      check("vec_ipc",   instr_pc,    vecs[i].pc);
      instr_ready  = 1'b1;
      BusImm       = vecs[i].imm;
      Branch       = vecs[i].br;
      Uncondbranch = vecs[i].ub;
      ALUZero      = vecs[i].zero;
      @(negedge CLK);
      clear_ctl();
      check("vec_next",    currentpc, vecs[i].nxt);
      check("vec_retired", retired,   64'(i + 2));
      check("vec_fault",   fault,     0);
    end

    // ---------------- watchdog timeout ----------------
    // The last vector's accept edge entered FETCH; this cycle is the first
    // with imem_req high.
    check("to_req_start", imem_req, 1);
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge CLK);
      check("to_fault", fault, (k == TIMEOUT) ? 64'd1 : 64'd0);
    end
    check("to_req_drop", imem_req,  0);
    check("to_pc_hold",  currentpc, 64'h104);
    imem_ack  = 1'b1;
    imem_data = 32'h1234_5678;
    @(negedge CLK);
    imem_ack = 1'b0;
    @(negedge CLK);
    check("late_ack_valid", instr_valid, 0);
    check("late_ack_fault", fault,       1);
    check("late_ack_pc",    currentpc,   64'h104);
    check("late_ack_ret",   retired,     9);

    // ---------------- misaligned target ----------------
    reset_and_boot(64'h400);
    check("mis_boot_pc", currentpc, 64'h400);
    imem_ack  = 1'b1;
    imem_data = 32'h1400_0000;
    @(negedge CLK);
    imem_ack     = 1'b0;
    instr_ready  = 1'b1;
    Uncondbranch = 1'b1;
    BusImm       = 64'h2;
    @(negedge CLK);
    clear_ctl();
    check("mis_fault", fault,       1);
    check("mis_pc",    currentpc,   64'h400);
    check("mis_ret",   retired,     1);
    check("mis_valid", instr_valid, 0);
    @(negedge CLK);
    check("mis_frozen_pc", currentpc, 64'h400);
    check("mis_req",       imem_req,  0);

    // ---------------- asynchronous reset mid-FETCH ----------------
    reset_and_boot(64'h400);
    check("mid_in_fetch", imem_req, 1);
    imem_ack  = 1'b1;
    imem_data = 32'hCAFE_F00D;
    resetl    = 1'b0;
    #1;
    check("async_req",   imem_req,  0);
    check("async_pc",    currentpc, 0);
    check("async_ret",   retired,   0);
    check("async_fault", fault,     0);
    @(negedge CLK);
    check("async_ack_ignored", instr_valid, 0);
    check("async_instr",       instr,       0);
    imem_ack = 1'b0;
    startpc  = 64'h800;
    resetl   = 1'b1;
    @(negedge CLK);
    check("reboot_pc",  currentpc, 64'h800);
    check("reboot_ret", retired,   0);
    check("reboot_req", imem_req,  1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
